newt_shift_pipe: RTL and testbench

//   Parametrised, multi-cycle successor to the single-bit top-of-word shift decode on the A bus.

---
 rtl/newt_shift_pipe.sv | 128 ++++++++++++
 tb/tb_newt_shift_pipe.sv | 124 ++++++++++++
 2 files changed

// File: rtl/newt_shift_pipe.sv
// Multi-cycle shift unit for the A bus: decodes the shift-group control word and
// shifts the captured operand by up to STEP bits per cycle behind valid/ready handshakes.
module newt_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_hit
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] M_SRL  = 2'b00;
    localparam logic [1:0] M_SRA  = 2'b01;
    localparam logic [1:0] M_SLL  = 2'b10;
    localparam logic [1:0] M_PASS = 2'b11;

    // Truncates to 0 when STEP == WIDTH, but then rem never exceeds STEP.
    localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   rem_reg;
    logic [1:0]       mode_reg;
    logic             sign_reg;
    logic             hit_reg;

    logic             hit_dec;
    logic [1:0]       mode_dec;
    logic [SHW-1:0]   rem_start;
    logic [SHW-1:0]   step_k;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted_next;

    assign hit_dec  = ~ctrl[0] & ~ctrl[2] & ~ctrl[3] & ~ctrl[4] & ctrl[5] & ctrl[7];
    assign mode_dec = {ctrl[6], ctrl[1]};
    assign in_ready = (state_reg == IDLE) & ~rst;

    always_comb begin
        rem_start = '0;
        if (hit_dec && (mode_dec != M_PASS)) begin
            rem_start = shamt;
        end
    end

    always_comb begin
        step_k = rem_reg;
        if (32'(rem_reg) > STEP) begin
            step_k = STEP_K;
        end
    end

    // Upper bits vacated by a right shift of step_k; OR-ed in for the arithmetic fill.
    assign fill_mask = ~({WIDTH{1'b1}} >> step_k);

    always_comb begin
        shifted_next = data_reg;
        case (mode_reg)
            M_SRL:   shifted_next = data_reg >> step_k;
            M_SRA:   shifted_next = (data_reg >> step_k) | (sign_reg ? fill_mask : '0);
            M_SLL:   shifted_next = data_reg << step_k;
            default: shifted_next = data_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            mode_reg  <= M_SRL;
            sign_reg  <= 1'b0;
            hit_reg   <= 1'b0;
            result    <= '0;
            out_hit   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= hit_dec ? a : '0;
                        mode_reg <= mode_dec;
                        sign_reg <= a[WIDTH-1];
                        hit_reg  <= hit_dec;
                        rem_reg  <= rem_start;
                        if (rem_start != '0) begin
                            state_reg <= SHIFT;
                        end else begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            result    <= hit_dec ? a : '0;
                            out_hit   <= hit_dec;
                        end
                    end
                end
                SHIFT: begin
                    data_reg <= shifted_next;
                    rem_reg  <= rem_reg - step_k;
                    if (rem_reg == step_k) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        result    <= shifted_next;
                        out_hit   <= hit_reg;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_newt_shift_pipe.sv
// Directed bench for newt_shift_pipe (WIDTH=32, STEP=8) with hand-computed expectations.
module tb_newt_shift_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  ctrl = 8'h00;
    logic [31:0] a = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        out_hit;

    int errors = 0;
    int checks = 0;

    newt_shift_pipe #(.WIDTH(32), .STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_hit   (out_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, measure latency, hold in DONE for 'hold' cycles, then retire.
    task automatic run(input logic [7:0] c, input logic [31:0] av, input logic [4:0] sh,
                       input logic [31:0] exp_res, input logic exp_hit, input int exp_lat,
                       input int hold, input string tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; ctrl = c; a = av; shamt = sh; out_ready = 1'b0;
        chk({31'b0, in_ready}, 32'd1, {tag, "_in_ready"});
        @(posedge clk); #1;
        // Garbage on the request side must be ignored while busy.
        ctrl = 8'hE0; a = 32'hFFFF_FFFF; shamt = 5'd1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("%s: ctrl=%h a=%h shamt=%0d -> result=%h hit=%0d latency=%0d",
                 tag, c, av, sh, result, out_hit, lat);
        chk(32'(lat), 32'(exp_lat), {tag, "_latency"});
        chk(result, exp_res, {tag, "_result"});
        chk({31'b0, out_hit}, {31'b0, exp_hit}, {tag, "_hit"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({30'b0, out_valid, in_ready}, 32'd2, {tag, "_hold_flags"});
            chk(result, exp_res, {tag, "_hold_result"});
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk({30'b0, out_valid, in_ready}, 32'd1, {tag, "_retire"});
        out_ready = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk({30'b0, out_valid, out_hit}, 32'd0, "reset_flags");
        chk(result, 32'd0, "reset_result");
        chk({31'b0, in_ready}, 32'd0, "reset_in_ready");
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk({31'b0, in_ready}, 32'd1, "post_reset_in_ready");

        run(8'hA2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b1, 2, 0, "sra4");
        run(8'hA0, 32'hF000_000F, 5'd20, 32'h0000_0F00, 1'b1, 4, 0, "srl20");
        run(8'hE2, 32'h1234_5678, 5'd31, 32'h1234_5678, 1'b1, 1, 0, "pass");
        run(8'hE0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1, 5, 0, "sll31");
        run(8'hA3, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b0, 1, 0, "miss");
        run(8'hA2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1, 5, 0, "sra31_neg");
        run(8'hA2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 5, 0, "sra31_pos");
        run(8'hA0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1, 5, 0, "srl31");
        run(8'hA0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1, 1, 0, "srl0");
        run(8'hA2, 32'h8000_1234, 5'd8,  32'hFF80_0012, 1'b1, 2, 0, "sra8");

        // Backpressure followed by back-to-back requests.
        run(8'hE0, 32'h0000_00FF, 5'd12, 32'h000F_F000, 1'b1, 3, 5, "bp_sll12");
        run(8'hA0, 32'h0000_FF00, 5'd4,  32'h0000_0FF0, 1'b1, 2, 0, "b2b_1");
        run(8'hA2, 32'hF000_0000, 5'd16, 32'hFFFF_F000, 1'b1, 3, 0, "b2b_2");

        // Reset in the second SHIFT cycle of a long SLL.
        @(negedge clk);
        in_valid = 1'b1; ctrl = 8'hE0; a = 32'h1; shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk({30'b0, out_valid, in_ready}, 32'd0, "midrst_flags");
        chk(result, 32'd0, "midrst_result");
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk({30'b0, out_valid, in_ready}, 32'd1, "midrst_idle");
        repeat (6) @(posedge clk);
        #1;
        chk({30'b0, out_valid, out_hit}, 32'd0, "midrst_no_partial");
        run(8'hA0, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b1, 2, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
